// File: rtl/inquire_browser.sv
// Query-mode item browser: next/prev buttons step an index while inquire is high,
// with idle auto-exit. Optional auto-scan stepping is enabled by INQUIRE_AUTOSCAN_EN.
module inquire_browser #(
  parameter int ITEM_NUM    = 8,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int SCAN_CYC    = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inquire,
  input  logic             btn_next,
  input  logic             btn_prev,
  output logic [IDX_W-1:0] item_idx,
  output logic             active,
  output logic             timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ITEM_NUM - 1);
  localparam bit CFG_OK = (ITEM_NUM >= 2) && (TIMEOUT_CYC >= 4) && (SCAN_CYC >= 1)
                          && ((1 << IDX_W) >= ITEM_NUM);

  if (!CFG_OK) begin : g_bad_cfg
    $error("inquire_browser: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BROWSE  = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  logic             next_q;
  logic             prev_q;
  logic             next_press;
  logic             prev_press;
  logic             any_press;
  logic [CNT_W-1:0] idle_cnt;

`ifdef INQUIRE_AUTOSCAN_EN
  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
  logic [SCAN_W-1:0] scan_cnt;
`endif

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_LAST) ? '0 : v + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] v);
    return (v == '0) ? IDX_LAST : v - IDX_W'(1);
  endfunction

  // Edge registers always follow the button levels, whatever the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      next_q <= btn_next;
      prev_q <= btn_prev;
    end
  end

  assign next_press = btn_next & ~next_q;
  assign prev_press = btn_prev & ~prev_q;
  assign any_press  = next_press | prev_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      item_idx <= '0;
      active   <= 1'b0;
      timeout  <= 1'b0;
      idle_cnt <= '0;
`ifdef INQUIRE_AUTOSCAN_EN
      scan_cnt <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (inquire) begin
            state    <= BROWSE;
            active   <= 1'b1;
            item_idx <= '0;
            idle_cnt <= '0;
          end
        end
        BROWSE: begin
          // Dropping inquire wins over presses and the timeout in the same cycle.
          if (!inquire) begin
            state    <= IDLE;
            active   <= 1'b0;
            idle_cnt <= '0;
`ifdef INQUIRE_AUTOSCAN_EN
            scan_cnt <= '0;
`endif
          end else if (any_press) begin
            idle_cnt <= '0;
`ifdef INQUIRE_AUTOSCAN_EN
            scan_cnt <= '0;
`endif
            if (next_press && !prev_press) begin
              item_idx <= idx_inc(item_idx);
            end else if (prev_press && !next_press) begin
              item_idx <= idx_dec(item_idx);
            end
          end else if (idle_cnt == CNT_LAST) begin
            state    <= EXPIRED;
            active   <= 1'b0;
            timeout  <= 1'b1;
            idle_cnt <= '0;
`ifdef INQUIRE_AUTOSCAN_EN
            scan_cnt <= '0;
`endif
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
`ifdef INQUIRE_AUTOSCAN_EN
            // Auto-steps move the index but deliberately leave idle_cnt running.
            if (scan_cnt == SCAN_LAST) begin
              scan_cnt <= '0;
              item_idx <= idx_inc(item_idx);
            end else begin
              scan_cnt <= scan_cnt + SCAN_W'(1);
            end
`endif
          end
        end
        EXPIRED: begin
          if (!inquire) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inquire_browser.sv
// Bench for inquire_browser: per-cycle reference model feeds an expected queue,
// a negedge monitor pops and compares; directed scenarios then random traffic.
module tb_inquire_browser;
  localparam int ITEM_NUM    = 8;
  localparam int IDX_W       = 3;
  localparam int TIMEOUT_CYC = 20;
  localparam int SCAN_CYC    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inquire = 1'b0;
  logic             btn_next = 1'b0;
  logic             btn_prev = 1'b0;
  logic [IDX_W-1:0] item_idx;
  logic             active;
  logic             timeout;

  int total = 0;
  int bad   = 0;
  logic [IDX_W+1:0] exp_q[$];

  inquire_browser #(
    .ITEM_NUM   (ITEM_NUM),
    .IDX_W      (IDX_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SCAN_CYC   (SCAN_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inquire (inquire),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .item_idx(item_idx),
    .active  (active),
    .timeout (timeout)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: modes, quiet-cycle count and index kept as plain integers
  typedef enum {M_IDLE, M_BROWSE, M_EXPIRED} mode_t;
  mode_t m_mode  = M_IDLE;
  int    m_idx   = 0;
  int    m_quiet = 0;
  int    m_scan  = 0;
  bit    m_pn    = 1'b0;
  bit    m_pp    = 1'b0;

  always @(posedge clk) begin : model
    bit np, pp, tmo;
    tmo = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_idx = 0; m_quiet = 0; m_scan = 0; m_pn = 1'b0; m_pp = 1'b0;
    end else begin
      np = btn_next && !m_pn;
      pp = btn_prev && !m_pp;
      m_pn = btn_next;
      m_pp = btn_prev;
      case (m_mode)
        M_IDLE: if (inquire) begin
          m_mode = M_BROWSE; m_idx = 0; m_quiet = 0; m_scan = 0;
        end
        M_BROWSE: begin
          if (!inquire) begin
            m_mode = M_IDLE;
          end else if (np || pp) begin
            m_idx   = (m_idx + int'(np) - int'(pp) + ITEM_NUM) % ITEM_NUM;
            m_quiet = 0;
            m_scan  = 0;
          end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT_CYC) begin
              m_mode = M_EXPIRED;
              tmo    = 1'b1;
            end
`ifdef INQUIRE_AUTOSCAN_EN
            else begin
              m_scan++;
              if (m_scan == SCAN_CYC) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % ITEM_NUM;
              end
            end
`endif
          end
        end
        default: if (!inquire) m_mode = M_IDLE;
      endcase
    end
    exp_q.push_back({m_mode == M_BROWSE, tmo, IDX_W'(m_idx)});
  end

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [IDX_W+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle{active,timeout,idx}", {29'd0, active, timeout, item_idx}, {29'd0, e});
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic press_next();
    btn_next = 1'b1; tick(1); btn_next = 1'b0; tick(1);
  endtask

  task automatic press_prev();
    btn_prev = 1'b1; tick(1); btn_prev = 1'b0; tick(1);
  endtask

  task automatic expect_out(input string tag, input int idx, input bit act);
`ifndef INQUIRE_AUTOSCAN_EN
    check({tag, ".idx"}, {29'd0, item_idx}, idx);
    check({tag, ".active"}, {31'd0, active}, {31'd0, act});
`endif
  endtask

  initial begin : stimulus
    int  len;
    bit  busy;
    tick(3);
    expect_out("reset", 0, 1'b0);
    check("reset.timeout", {31'd0, timeout}, 0);
    rst_n = 1'b1;
    tick(2);

    // enter browse and step forward
    inquire = 1'b1;
    tick(2);
    expect_out("enter", 0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      press_next();
      expect_out("next_step", k, 1'b1);
    end

    // wrap in both directions
    repeat (3) press_prev();
    expect_out("back_to_0", 0, 1'b1);
    press_prev();
    expect_out("wrap_0_to_7", 7, 1'b1);
    press_next();
    expect_out("wrap_7_to_0", 0, 1'b1);

    // simultaneous presses cancel
    repeat (4) press_next();
    btn_next = 1'b1; btn_prev = 1'b1; tick(1);
    btn_next = 1'b0; btn_prev = 1'b0; tick(1);
    expect_out("cancel_at_4", 4, 1'b1);

    // idle timeout, sticky EXPIRED until inquire drops
    tick(TIMEOUT_CYC + 5);
    expect_out("expired", 4, 1'b0);
    press_next();
    tick(4);
    expect_out("expired_ignores", 4, 1'b0);
    inquire = 1'b0; tick(2);
    inquire = 1'b1; tick(2);
    expect_out("reenter", 0, 1'b1);

    // async reset mid-browse with next held
    repeat (4) press_next();
    btn_next = 1'b1; tick(2);
    expect_out("before_reset", 5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset.idx", {29'd0, item_idx}, 0);
    check("async_reset.active", {31'd0, active}, 0);
    check("async_reset.timeout", {31'd0, timeout}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    expect_out("held_across_reset", 0, 1'b1);
    btn_next = 1'b0;
    tick(2);

`ifdef INQUIRE_AUTOSCAN_EN
    inquire = 1'b0; tick(2);
    inquire = 1'b1; tick(TIMEOUT_CYC + 6);
`endif

    // random traffic: busy and quiet segments, inquire toggles, rare resets
    for (int s = 0; s < 40; s++) begin
      len  = $urandom_range(1, 30);
      busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) < 5) inquire = ~inquire;
        if (busy) begin
          btn_next = ($urandom_range(0, 2) == 0);
          btn_prev = ($urandom_range(0, 3) == 0);
        end
        tick(1);
      end
    end

    inquire = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
